if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
Instruction-fetch stage directly upstream of ID. Owns the program counter and issues one fetch request at a time to the Icache. It tags each returned instruction with its PC for if_id_reg/ID, and it redirects on a taken branch from EX or a jal/jalr from ID. Responses belonging to the wrong path after a redirect are discarded, so ID never sees a stale instruction.

Parameters:
RESET_PC, 32'h0000_0000, address of the first fetch after reset.

Ports:
clk  input  1  clock, all state updates on posedge.
rst  input  1  reset; synchronous, active-high.
fc_stall_if_i  input  1  stall from fc; no new request is issued while high.
ex_btype_taken_i  input  1  taken branch resolved in EX.
ex_btype_pc_i  input  32  branch target.
id_jump_flag_i  input  1  jal/jalr decoded in ID.
id_jump_pc_i  input  32  jump target.
if_req_o  output  1  fetch request valid.
if_addr_o  output  32  fetch address, word aligned.
Icache_req_ready_i  input  1  Icache accepts the request this cycle when high together with if_req_o.
Icache_ready_i  input  1  Icache response valid (instruction itself goes Icache to ID directly).
if_inst_valid_o  output  1  response this cycle is on the correct path and is for if_pc_o.
if_pc_o  output  32  PC of the outstanding/returned fetch, to if_id_reg.

Behaviour:
- Registers:
  - pc: next address to fetch.
  - out_pc: address of the accepted, outstanding request.
  - state.
- States:
  - BOOT: one cycle after reset.
  - REQ: request presented, awaiting acceptance.
  - WAIT: one request outstanding, awaiting response.
  - DROP: outstanding response will be discarded.
- Reset (rst=1 at posedge):
  - pc=RESET_PC, out_pc=RESET_PC, state=BOOT.
  - Outputs: if_req_o=0, if_inst_valid_o=0, if_addr_o=RESET_PC, if_pc_o=RESET_PC.
  - Reset mid-operation abandons any outstanding request. Icache shares rst, so no response arrives afterwards.
- Request outputs:
  - if_req_o = (state==REQ) & !fc_stall_if_i & !redirect.
  - if_addr_o = pc.
  - Max one outstanding request.
- Redirect and target alignment:
  - redirect = ex_btype_taken_i | id_jump_flag_i.
  - target = ex_btype_taken_i ? ex_btype_pc_i : id_jump_pc_i. EX branch wins over ID jump because it is older.
  - target[1:0] forced to 2'b00.
- Transitions:
  - BOOT -> REQ unconditionally.
  - REQ, redirect: pc<=target, stay REQ. No request is issued that cycle.
  - REQ, if_req_o & Icache_req_ready_i: out_pc<=pc, pc<=pc+4 (wraps modulo 2^32), -> WAIT.
  - REQ, otherwise (stalled or not accepted): hold everything.
  - WAIT, Icache_ready_i & !redirect: if_inst_valid_o=1 combinationally, -> REQ.
  - WAIT, Icache_ready_i & redirect: if_inst_valid_o=0, pc<=target, -> REQ.
  - WAIT, !Icache_ready_i & redirect: pc<=target, -> DROP.
  - WAIT, stall only: stay WAIT. A response arriving during the stall is still flagged valid; ID buffers it.
  - DROP: if_inst_valid_o always 0. A redirect updates pc (latest target wins). On Icache_ready_i -> REQ.
- if_pc_o = out_pc at all times. It is meaningful whenever if_inst_valid_o=1.
- Throughput: at most one instruction per 2 cycles (response cycle, then new request cycle), plus Icache latency.
- Simultaneous events:
  - Redirect + acceptance cannot coincide, because redirect gates if_req_o.
  - Stall + redirect: pc updates, request still gated.

Test Plan:
1. Reset release, RESET_PC=0, Icache_req_ready_i=1, 1-cycle latency -> if_req_o rises 1 cycle after BOOT. if_addr_o=0x0, 0x4, 0x8 on successive requests. if_inst_valid_o pulses with if_pc_o=0x0, 0x4, 0x8.
2. id_jump_flag_i=1, id_jump_pc_i=0x103 while in WAIT with no response -> DROP. The next response gives if_inst_valid_o=0. The next request has if_addr_o=0x100.
3. ex_btype_taken_i=1 (pc 0x200) and id_jump_flag_i=1 (pc 0x300) in the same cycle -> next if_addr_o=0x200.
4. fc_stall_if_i=1 for 5 cycles in REQ -> if_req_o=0 throughout with pc unchanged. In WAIT, a response during the stall gives if_inst_valid_o=1 with the correct if_pc_o. After the stall the request resumes at pc+4.
5. Icache_req_ready_i=0 for 3 cycles -> if_req_o and if_addr_o held stable until accepted.
6. rst asserted while in WAIT at pc 0x40 -> next cycle if_req_o=0, if_pc_o=RESET_PC, then the fetch restarts at RESET_PC. pc=0xFFFF_FFFC accepted -> next if_addr_o=0x0.

Source files
------------

// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch : instruction-fetch stage, directly upstream of ID.
//
// This stage owns the program counter and keeps at most one fetch request
// outstanding to the Icache. Each returned instruction is tagged with its PC.
// The instruction itself goes straight from the Icache to ID.
//
// Two sources can redirect the fetch path:
//   - a taken branch resolved in EX
//   - a jal/jalr decoded in ID
// The EX branch has priority because it is the older instruction. If a
// redirect happens while a request is outstanding, the response for that
// request is discarded, so ID never sees a wrong-path instruction.
//
// Ports:
//   clk                 clock; all state updates on the rising edge
//   rst                 synchronous active-high reset
//   fc_stall_if_i       stall from flow control; blocks new requests
//   ex_btype_taken_i    taken branch resolved in EX
//   ex_btype_pc_i       branch target
//   id_jump_flag_i      jal/jalr decoded in ID
//   id_jump_pc_i        jump target
//   if_req_o            fetch request valid
//   if_addr_o           fetch address (word aligned)
//   Icache_req_ready_i  Icache accepts the request when high with if_req_o
//   Icache_ready_i      Icache response valid
//   if_inst_valid_o     current response is on the correct path
//   if_pc_o             PC of the outstanding / returned fetch
// -----------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fc_stall_if_i,
  input  logic        ex_btype_taken_i,
  input  logic [31:0] ex_btype_pc_i,
  input  logic        id_jump_flag_i,
  input  logic [31:0] id_jump_pc_i,
  output logic        if_req_o,
  output logic [31:0] if_addr_o,
  input  logic        Icache_req_ready_i,
  input  logic        Icache_ready_i,
  output logic        if_inst_valid_o,
  output logic [31:0] if_pc_o
);

  // State encoding.
  localparam logic [1:0] ST_BOOT = 2'd0;  // single cycle after reset
  localparam logic [1:0] ST_REQ  = 2'd1;  // request presented, awaiting accept
  localparam logic [1:0] ST_WAIT = 2'd2;  // one request outstanding
  localparam logic [1:0] ST_DROP = 2'd3;  // outstanding response is wrong-path

  logic [1:0]  r_state;
  logic [31:0] r_pc;      // next address to fetch
  logic [31:0] r_out_pc;  // address of the accepted, outstanding request

  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_accept;

  // The EX branch is older than the ID jump, so its target takes precedence.
  // Targets are forced to word alignment.
  assign w_redirect = ex_btype_taken_i | id_jump_flag_i;
  assign w_target   = {(ex_btype_taken_i ? ex_btype_pc_i[31:2] : id_jump_pc_i[31:2]), 2'b00};

  // A redirect suppresses the request in the same cycle. This is why a
  // redirect and a request acceptance can never happen together.
  assign if_req_o  = (r_state == ST_REQ) && !fc_stall_if_i && !w_redirect;
  assign if_addr_o = r_pc;
  assign w_accept  = if_req_o && Icache_req_ready_i;

  // A response is flagged valid even while stalled (ID buffers it), but not
  // when a redirect arrives in the same cycle, because then it is wrong-path.
  assign if_inst_valid_o = (r_state == ST_WAIT) && Icache_ready_i && !w_redirect;
  assign if_pc_o         = r_out_pc;

  // NOTE: sequential state uses non-blocking (<=) assignments only, so every
  // register samples values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_BOOT;
      r_pc     <= RESET_PC;
      r_out_pc <= RESET_PC;
    end else begin
      case (r_state)
        ST_BOOT: r_state <= ST_REQ;

        ST_REQ: begin
          if (w_redirect) begin
            r_pc <= w_target;
          end else if (w_accept) begin
            r_out_pc <= r_pc;
            r_pc     <= r_pc + 32'd4;  // wraps modulo 2^32
            r_state  <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (w_redirect) begin
            r_pc <= w_target;
          end
          if (Icache_ready_i) begin
            r_state <= ST_REQ;
          end else if (w_redirect) begin
            r_state <= ST_DROP;
          end
        end

        ST_DROP: begin
          // If several redirects arrive while a response is being dropped,
          // the most recent target is kept.
          if (w_redirect) begin
            r_pc <= w_target;
          end
          if (Icache_ready_i) begin
            r_state <= ST_REQ;
          end
        end

        default: r_state <= ST_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// -----------------------------------------------------------------------------
// tb_if_fetch : directed self-checking bench for if_fetch (RESET_PC = 0).
//
// Inputs are driven 1 ns after each rising edge. Outputs are sampled 1 ns
// after that, so every sample is taken well away from the active clock edge.
// -----------------------------------------------------------------------------
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        fc_stall_if_i;
  logic        ex_btype_taken_i;
  logic [31:0] ex_btype_pc_i;
  logic        id_jump_flag_i;
  logic [31:0] id_jump_pc_i;
  logic        if_req_o;
  logic [31:0] if_addr_o;
  logic        Icache_req_ready_i;
  logic        Icache_ready_i;
  logic        if_inst_valid_o;
  logic [31:0] if_pc_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk                (clk),
    .rst                (rst),
    .fc_stall_if_i      (fc_stall_if_i),
    .ex_btype_taken_i   (ex_btype_taken_i),
    .ex_btype_pc_i      (ex_btype_pc_i),
    .id_jump_flag_i     (id_jump_flag_i),
    .id_jump_pc_i       (id_jump_pc_i),
    .if_req_o           (if_req_o),
    .if_addr_o          (if_addr_o),
    .Icache_req_ready_i (Icache_req_ready_i),
    .Icache_ready_i     (Icache_ready_i),
    .if_inst_valid_o    (if_inst_valid_o),
    .if_pc_o            (if_pc_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs may be changed on return.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let the combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  // Starting in REQ with Icache_req_ready_i=1: the request is accepted, then a
  // response arrives one cycle later. The DUT ends back in REQ.
  task automatic do_fetch(input string tag, input logic [31:0] addr);
    Icache_ready_i = 1'b0;
    settle();
    check({tag, "_req"},  {31'd0, if_req_o}, 32'd1);
    check({tag, "_addr"}, if_addr_o, addr);
    tick();
    Icache_ready_i = 1'b1;
    settle();
    check({tag, "_valid"}, {31'd0, if_inst_valid_o}, 32'd1);
    check({tag, "_pc"},    if_pc_o, addr);
    tick();
    Icache_ready_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fc_stall_if_i = 1'b0;
    ex_btype_taken_i = 1'b0; ex_btype_pc_i = '0;
    id_jump_flag_i = 1'b0; id_jump_pc_i = '0;
    Icache_req_ready_i = 1'b1; Icache_ready_i = 1'b0;
    tick(); tick();

    // Reset state.
    settle();
    check("rst_req",   {31'd0, if_req_o}, 32'd0);
    check("rst_valid", {31'd0, if_inst_valid_o}, 32'd0);
    check("rst_addr",  if_addr_o, 32'h0);
    check("rst_pc",    if_pc_o, 32'h0);

    // 1: BOOT for one cycle, then sequential fetches.
    rst = 1'b0;
    tick();                       // BOOT -> REQ at this edge
    do_fetch("seq0", 32'h0);
    do_fetch("seq1", 32'h4);
    do_fetch("seq2", 32'h8);

    // 2: jump while waiting with no response -> DROP, aligned target.
    settle();
    check("t2_addr", if_addr_o, 32'hC);
    tick();                       // accepted, now WAIT
    id_jump_flag_i = 1'b1; id_jump_pc_i = 32'h103;
    settle();
    check("t2_req_gate", {31'd0, if_req_o}, 32'd0);
    tick();                       // -> DROP, pc=0x100
    id_jump_flag_i = 1'b0;
    settle();
    check("t2_drop_req", {31'd0, if_req_o}, 32'd0);
    tick();
    Icache_ready_i = 1'b1;
    settle();
    check("t2_drop_valid", {31'd0, if_inst_valid_o}, 32'd0);
    tick();                       // -> REQ
    do_fetch("t2_fetch", 32'h100);

    // 3: EX branch and ID jump in the same cycle; EX wins.
    ex_btype_taken_i = 1'b1; ex_btype_pc_i = 32'h200;
    id_jump_flag_i   = 1'b1; id_jump_pc_i  = 32'h300;
    settle();
    check("t3_req_gate", {31'd0, if_req_o}, 32'd0);
    tick();
    ex_btype_taken_i = 1'b0; id_jump_flag_i = 1'b0;
    do_fetch("t3_fetch", 32'h200);

    // 4: five stalled cycles in REQ, then a response during a stall in WAIT.
    fc_stall_if_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      check($sformatf("t4_stall_req%0d", i), {31'd0, if_req_o}, 32'd0);
      check($sformatf("t4_stall_addr%0d", i), if_addr_o, 32'h204);
      tick();
    end
    fc_stall_if_i = 1'b0;
    settle();
    check("t4_resume_req", {31'd0, if_req_o}, 32'd1);
    tick();                       // accepted 0x204
    fc_stall_if_i = 1'b1; Icache_ready_i = 1'b1;
    settle();
    check("t4_wait_valid", {31'd0, if_inst_valid_o}, 32'd1);
    check("t4_wait_pc", if_pc_o, 32'h204);
    tick();                       // -> REQ, still stalled
    Icache_ready_i = 1'b0;
    settle();
    check("t4_post_req", {31'd0, if_req_o}, 32'd0);
    fc_stall_if_i = 1'b0;
    settle();
    check("t4_next_addr", if_addr_o, 32'h208);

    // 5: Icache refuses the request for three cycles.
    Icache_req_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("t5_hold_req%0d", i), {31'd0, if_req_o}, 32'd1);
      check($sformatf("t5_hold_addr%0d", i), if_addr_o, 32'h208);
      tick();
    end
    Icache_req_ready_i = 1'b1;
    do_fetch("t5_fetch", 32'h208);

    // 6: reset while in WAIT at 0x40.
    id_jump_flag_i = 1'b1; id_jump_pc_i = 32'h40;
    tick();
    id_jump_flag_i = 1'b0;
    settle();
    check("t6_addr40", if_addr_o, 32'h40);
    tick();                       // accepted, WAIT at 0x40
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    check("t6_rst_req", {31'd0, if_req_o}, 32'd0);
    check("t6_rst_pc",  if_pc_o, 32'h0);
    tick();                       // BOOT -> REQ
    do_fetch("t6_restart", 32'h0);

    // Response coinciding with a redirect is discarded.
    tick();                       // accept 0x4, WAIT
    Icache_ready_i = 1'b1;
    ex_btype_taken_i = 1'b1; ex_btype_pc_i = 32'hFFFF_FFFE;
    settle();
    check("t6_redir_valid", {31'd0, if_inst_valid_o}, 32'd0);
    tick();                       // -> REQ, pc=0xFFFF_FFFC
    ex_btype_taken_i = 1'b0; Icache_ready_i = 1'b0;
    do_fetch("t6_top", 32'hFFFF_FFFC);
    settle();
    check("t6_wrap_addr", if_addr_o, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
